// File: rtl/sp_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : sp_mem_arbiter_if
// Description : Core-side request bus and memory-side port of the SP
//               data-memory arbiter, bundled as one interface.
// Revision    : 1.0 - initial release
// ============================================================================
interface sp_mem_arbiter_if #(
    parameter int N_CORES = 4,
    parameter int DW      = 16
);
    logic [N_CORES-1:0]    req;
    logic [N_CORES-1:0]    we;
    logic [N_CORES*DW-1:0] addr;
    logic [N_CORES*DW-1:0] wdata;
    logic [N_CORES-1:0]    ack;
    logic [DW-1:0]         rdata;
    logic                  busy;

    logic                  mem_en;
    logic                  mem_we;
    logic [DW-1:0]         mem_addr;
    logic [DW-1:0]         mem_wdata;
    logic [DW-1:0]         mem_rdata;

    // Arbiter view
    modport slave (
        input  req, we, addr, wdata, mem_rdata,
        output ack, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
    );

    // Cores plus memory view
    modport master (
        output req, we, addr, wdata, mem_rdata,
        input  ack, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/sp_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sp_mem_arbiter
// Description : Round-robin arbiter giving N_CORES SP cores access to one
//               synchronous data-memory port, one transaction at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module sp_mem_arbiter #(
    parameter int N_CORES = 4,
    parameter int DW      = 16
) (
    input  logic              clk,
    input  logic              reset,
    sp_mem_arbiter_if.slave   bus
);

    localparam int c_PW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_ACK     = 2'd3
    } state_t;

    state_t              r_state;
    logic [c_PW-1:0]     r_ptr;
    logic [c_PW-1:0]     r_owner;
    logic                r_load;
    logic [N_CORES-1:0]  r_ack;
    logic [DW-1:0]       r_rdata;

    logic [N_CORES-1:0]  w_rot;
    logic [c_PW-1:0]     w_off;
    logic                w_found;
    logic [c_PW:0]       w_sum;
    logic [c_PW-1:0]     w_next_owner;
    logic [c_PW-1:0]     w_ptr_next;
    logic [N_CORES-1:0]  w_owner_onehot;
    logic                w_sel_we;
    logic [DW-1:0]       w_sel_addr;
    logic [DW-1:0]       w_sel_wdata;
    logic                w_issue;

    // Requests rotated so bit 0 is the core at ptr; first set bit wins.
    assign w_rot = N_CORES'({bus.req, bus.req} >> r_ptr);

    always_comb begin
        w_off   = '0;
        w_found = 1'b0;
        for (int j = 0; j < N_CORES; j++) begin
            if (!w_found && w_rot[j]) begin
                w_found = 1'b1;
                w_off   = c_PW'(j);
            end
        end
    end

    always_comb begin
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        if (w_sum >= (c_PW+1)'(N_CORES)) begin
            w_sum = w_sum - (c_PW+1)'(N_CORES);
        end
        w_next_owner = w_sum[c_PW-1:0];
    end

    assign w_ptr_next = (r_owner == c_PW'(N_CORES-1)) ? '0 : r_owner + 1'b1;

    always_comb begin
        w_owner_onehot = '0;
        w_sel_we       = 1'b0;
        w_sel_addr     = '0;
        w_sel_wdata    = '0;
        for (int i = 0; i < N_CORES; i++) begin
            if (r_owner == c_PW'(i)) begin
                w_owner_onehot[i] = 1'b1;
                w_sel_we          = bus.we[i];
                w_sel_addr        = bus.addr[i*DW +: DW];
                w_sel_wdata       = bus.wdata[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_load  <= 1'b0;
            r_ack   <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ack <= '0;
                    if (|bus.req) begin
                        r_owner <= w_next_owner;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // Direction latched here so a requester dropping req
                    // later cannot change how the capture behaves.
                    r_load  <= ~w_sel_we;
                    r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    if (r_load) begin
                        r_rdata <= bus.mem_rdata;
                    end
                    r_ack   <= w_owner_onehot;
                    r_state <= S_ACK;
                end
                S_ACK: begin
                    r_ack   <= '0;
                    r_ptr   <= w_ptr_next;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ack   <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign w_issue       = (r_state == S_ISSUE);
    assign bus.mem_en    = w_issue;
    assign bus.mem_we    = w_issue & w_sel_we;
    assign bus.mem_addr  = w_issue ? w_sel_addr  : '0;
    assign bus.mem_wdata = w_issue ? w_sel_wdata : '0;
    assign bus.ack       = r_ack;
    assign bus.rdata     = r_rdata;
    assign bus.busy      = (r_state != S_IDLE) | (|bus.req);

endmodule
`default_nettype wire

// File: tb/tb_sp_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sp_mem_arbiter
// Description : Directed self-checking bench for sp_mem_arbiter (4-core and
//               1-core instances, each with a synchronous memory model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sp_mem_arbiter;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    sp_mem_arbiter_if #(.N_CORES(4), .DW(16)) bus0 ();
    sp_mem_arbiter_if #(.N_CORES(1), .DW(16)) bus1 ();

    sp_mem_arbiter #(.N_CORES(4), .DW(16)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    sp_mem_arbiter #(.N_CORES(1), .DW(16)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] mem0 [256];
    logic [15:0] mem1 [256];

    initial begin : mem0_model
        for (int i = 0; i < 256; i++) mem0[i] = 16'h0000;
        mem0[8'h10] = 16'h1234;
        mem0[8'h05] = 16'h5555;
        for (int c = 0; c < 4; c++) mem0[8'h40 + c] = 16'hA000 + 16'(c);
        mem0[8'h50] = 16'h5050;
        mem0[8'h53] = 16'h5353;
        mem0[8'h60] = 16'h6060;
        bus0.mem_rdata <= '0;
        forever begin
            @(posedge clk);
            if (bus0.mem_en) begin
                if (bus0.mem_we) mem0[bus0.mem_addr[7:0]] = bus0.mem_wdata;
                else bus0.mem_rdata <= mem0[bus0.mem_addr[7:0]];
            end
        end
    end

    initial begin : mem1_model
        for (int i = 0; i < 256; i++) mem1[i] = 16'h0101 * 16'(i);
        bus1.mem_rdata <= '0;
        forever begin
            @(posedge clk);
            if (bus1.mem_en) begin
                if (bus1.mem_we) mem1[bus1.mem_addr[7:0]] = bus1.mem_wdata;
                else bus1.mem_rdata <= mem1[bus1.mem_addr[7:0]];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin : stimulus
        reset       = 1'b1;
        bus0.req    = '0;
        bus0.we     = '0;
        bus0.addr   = '0;
        bus0.wdata  = '0;
        bus1.req    = '0;
        bus1.we     = '0;
        bus1.addr   = '0;
        bus1.wdata  = '0;
        step();
        step();
        reset = 1'b0;

        // Reset state
        chk("rst_ack",    32'(bus0.ack),    32'h0);
        chk("rst_mem_en", 32'(bus0.mem_en), 32'h0);
        chk("rst_mem_we", 32'(bus0.mem_we), 32'h0);
        chk("rst_addr",   32'(bus0.mem_addr), 32'h0);
        chk("rst_rdata",  32'(bus0.rdata),  32'h0);
        chk("rst_busy",   32'(bus0.busy),   32'h0);
        chk("rst_rdata1", 32'(bus1.rdata),  32'h0);

        // Single load from core 2
        bus0.req = 4'b0100;
        bus0.addr[2*16 +: 16] = 16'h0010;
        step();
        chk("ld_issue_en",   32'(bus0.mem_en),   32'h1);
        chk("ld_issue_we",   32'(bus0.mem_we),   32'h0);
        chk("ld_issue_addr", 32'(bus0.mem_addr), 32'h0010);
        chk("ld_issue_busy", 32'(bus0.busy),     32'h1);
        chk("ld_issue_ack",  32'(bus0.ack),      32'h0);
        step();
        chk("ld_cap_en",   32'(bus0.mem_en),   32'h0);
        chk("ld_cap_addr", 32'(bus0.mem_addr), 32'h0);
        chk("ld_cap_ack",  32'(bus0.ack),      32'h0);
        step();
        chk("ld_ack",   32'(bus0.ack),   32'h4);
        chk("ld_rdata", 32'(bus0.rdata), 32'h1234);
        bus0.req = 4'b0000;
        step();
        chk("ld_idle_ack",  32'(bus0.ack),  32'h0);
        chk("ld_idle_busy", 32'(bus0.busy), 32'h0);

        // Single store from core 1
        bus0.req = 4'b0010;
        bus0.we  = 4'b0010;
        bus0.addr[1*16 +: 16]  = 16'h0020;
        bus0.wdata[1*16 +: 16] = 16'hBEEF;
        step();
        chk("st_issue_we",   32'(bus0.mem_we),    32'h1);
        chk("st_issue_addr", 32'(bus0.mem_addr),  32'h0020);
        chk("st_issue_wd",   32'(bus0.mem_wdata), 32'hBEEF);
        step();
        chk("st_cap_we", 32'(bus0.mem_we),    32'h0);
        chk("st_cap_wd", 32'(bus0.mem_wdata), 32'h0);
        step();
        chk("st_ack",   32'(bus0.ack),   32'h2);
        chk("st_rdata", 32'(bus0.rdata), 32'h1234);
        chk("st_mem",   32'(mem0[8'h20]), 32'hBEEF);
        bus0.req = 4'b0000;
        bus0.we  = 4'b0000;
        step();
        chk("st_idle_ack", 32'(bus0.ack), 32'h0);

        // All four cores at once after reset: served 0,1,2,3
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("all_rst_rdata", 32'(bus0.rdata), 32'h0);
        bus0.req = 4'b1111;
        for (int c = 0; c < 4; c++) bus0.addr[c*16 +: 16] = 16'h0040 + 16'(c);
        for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("all_issue_addr%0d", c), 32'(bus0.mem_addr), 32'h40 + 32'(c));
            chk($sformatf("all_issue_busy%0d", c), 32'(bus0.busy), 32'h1);
            step();
            step();
            chk($sformatf("all_ack%0d", c),   32'(bus0.ack),   32'(1 << c));
            chk($sformatf("all_rdata%0d", c), 32'(bus0.rdata), 32'hA000 + 32'(c));
            bus0.req[c] = 1'b0;
            step();
            chk($sformatf("all_idle_ack%0d", c),  32'(bus0.ack),  32'h0);
            chk($sformatf("all_idle_busy%0d", c), 32'(bus0.busy), (c < 3) ? 32'h1 : 32'h0);
        end

        // Cores 0 and 3 continuously: grants alternate 0,3,0,3
        bus0.req = 4'b1001;
        bus0.addr[0*16 +: 16] = 16'h0050;
        bus0.addr[3*16 +: 16] = 16'h0053;
        for (int n = 0; n < 4; n++) begin
            int c;
            c = (n % 2 == 1) ? 3 : 0;
            step();
            chk($sformatf("rr_issue_addr%0d", n), 32'(bus0.mem_addr), 32'h50 + 32'(c));
            step();
            step();
            chk($sformatf("rr_ack%0d", n),   32'(bus0.ack),   32'(1 << c));
            chk($sformatf("rr_rdata%0d", n), 32'(bus0.rdata), 32'h5050 + 32'h0101 * 32'(c));
            if (n == 3) bus0.req = 4'b0000;
            step();
            chk($sformatf("rr_idle_ack%0d", n), 32'(bus0.ack), 32'h0);
        end

        // Move ptr to 2 with a core-1 store
        bus0.req = 4'b0010;
        bus0.we  = 4'b0010;
        bus0.addr[1*16 +: 16]  = 16'h0021;
        bus0.wdata[1*16 +: 16] = 16'h1111;
        step();
        step();
        step();
        chk("pre_ack", 32'(bus0.ack), 32'h2);
        bus0.req = 4'b0000;
        bus0.we  = 4'b0000;
        step();

        // Core-2 load to 0x0005 aborted by reset during CAPTURE
        bus0.req = 4'b0100;
        bus0.addr[2*16 +: 16] = 16'h0005;
        step();
        chk("ab_issue_addr", 32'(bus0.mem_addr), 32'h0005);
        step();
        reset    = 1'b1;
        bus0.req = 4'b0101;
        bus0.addr[0*16 +: 16] = 16'h0060;
        step();
        chk("ab_ack",    32'(bus0.ack),    32'h0);
        chk("ab_rdata",  32'(bus0.rdata),  32'h0);
        chk("ab_mem_en", 32'(bus0.mem_en), 32'h0);
        reset = 1'b0;
        step();
        chk("ab_first_addr", 32'(bus0.mem_addr), 32'h0060);
        step();
        chk("ab_cap_ack", 32'(bus0.ack), 32'h0);
        step();
        chk("ab_first_ack",   32'(bus0.ack),   32'h1);
        chk("ab_first_rdata", 32'(bus0.rdata), 32'h6060);
        bus0.req[0] = 1'b0;
        step();
        chk("ab_idle_ack", 32'(bus0.ack), 32'h0);
        step();
        chk("ab_second_addr", 32'(bus0.mem_addr), 32'h0005);
        step();
        step();
        chk("ab_second_ack",   32'(bus0.ack),   32'h4);
        chk("ab_second_rdata", 32'(bus0.rdata), 32'h5555);
        bus0.req = 4'b0000;
        step();
        chk("ab_end_busy", 32'(bus0.busy), 32'h0);

        // Single-core instance: back-to-back loads every 4 cycles
        bus1.req  = 1'b1;
        bus1.addr = 16'h0001;
        for (int n = 1; n <= 3; n++) begin
            step();
            chk($sformatf("one_issue_en%0d", n),   32'(bus1.mem_en),   32'h1);
            chk($sformatf("one_issue_addr%0d", n), 32'(bus1.mem_addr), 32'(n));
            step();
            step();
            chk($sformatf("one_ack%0d", n),   32'(bus1.ack),   32'h1);
            chk($sformatf("one_rdata%0d", n), 32'(bus1.rdata), 32'h0101 * 32'(n));
            if (n < 3) bus1.addr = 16'(n + 1);
            else bus1.req = 1'b0;
            step();
            chk($sformatf("one_idle_ack%0d", n), 32'(bus1.ack),    32'h0);
            chk($sformatf("one_idle_en%0d", n),  32'(bus1.mem_en), 32'h0);
        end
        step();
        chk("one_end_busy", 32'(bus1.busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sp_mem_arbiter.md
SP_MEM_ARBITER -- requirements
Module: sp_mem_arbiter

Interface
REQ-001 Parameter N_CORES, default 4, number of SP cores sharing one data-memory port (legal 1..8).
REQ-002 Parameter DW, default 16, data and address width.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  N_CORES  per-core access request; bit i from core i.
REQ-006 we  input  N_CORES  per-core write enable; 1 = store, 0 = load; valid while req[i]=1.
REQ-007 addr  input  N_CORES*DW  per-core address; core i at bits [i*DW +: DW].
REQ-008 wdata  input  N_CORES*DW  per-core store data; same packing as addr.
REQ-009 ack  output  N_CORES  one-cycle completion pulse to the owning core.
REQ-010 rdata  output  DW  load result register, shared by all cores.
REQ-011 mem_en  output  1  memory access strobe.
REQ-012 mem_we  output  1  memory write strobe.
REQ-013 mem_addr  output  DW  memory address.
REQ-014 mem_wdata  output  DW  memory write data.
REQ-015 mem_rdata  input  DW  memory read data; synchronous memory, valid in the cycle after the mem_en=1 cycle.
REQ-016 busy  output  1  high when state != IDLE or any req bit is high; used by the SM controller to stall.

Function
REQ-017 The FSM shall have four states: IDLE, ISSUE, CAPTURE, ACK; one transaction in flight at a time.
REQ-018 IDLE: if any req bit is high at the edge, register owner = first set bit searching ptr, ptr+1, ... mod N_CORES, and go to ISSUE; else stay in IDLE.
REQ-019 ISSUE: mem_en=1, mem_we=we[owner], mem_addr=addr[owner], mem_wdata=wdata[owner]; next state CAPTURE unconditionally.
REQ-020 CAPTURE: for a load, rdata <= mem_rdata at the closing edge; for a store, rdata holds; next state ACK unconditionally.
REQ-021 ACK: ack[owner]=1 and all other ack bits 0; ptr <= (owner+1) mod N_CORES; next state IDLE unconditionally.
REQ-022 Latency: req sampled in IDLE at edge k -> ISSUE cycle k+1 -> CAPTURE k+2 -> ACK k+3; rdata valid from cycle k+3 until the next load completes.
REQ-023 mem_en, mem_we and all ack bits shall be 0 in every state other than those stated above; mem_addr and mem_wdata shall be 0 outside ISSUE.
REQ-024 Requesters hold req, we, addr and wdata stable until ack; the arbiter samples we/addr/wdata combinationally from owner only in ISSUE.
REQ-025 A requester that drops req before ack shall still have its transaction completed and acked; no abort path.
REQ-026 Requests raised in ISSUE, CAPTURE or ACK shall be held off until the next IDLE; none are lost while req stays high.
REQ-027 Round-robin: a continuously requesting core waits at most N_CORES-1 other transactions.
REQ-028 Back-to-back transactions from the same or different cores shall be separated by exactly one IDLE cycle (4-cycle period).
REQ-029 ptr shall wrap from N_CORES-1 to 0.

Reset
REQ-030 While reset=1 at an edge: state <= IDLE, ptr <= 0, owner <= 0, rdata <= 0; outputs ack=0, mem_en=0, mem_we=0 from the following cycle.
REQ-031 Reset asserted mid-transaction shall abort it: no ack is issued and rdata is not updated by that transaction.

Verification
REQ-032 Single load: core 2 req, we=0, addr=0x0010, mem holds 0x1234 -> mem_en=1 at k+1 with mem_addr=0x0010, ack[2]=1 at k+3, rdata=0x1234.
REQ-033 Single store: core 1 req, we=1, addr=0x0020, wdata=0xBEEF -> mem_we=1 at k+1, ack[1] at k+3, memory[0x0020]=0xBEEF, rdata unchanged.
REQ-034 All four cores request simultaneously after reset -> acks in order core 0,1,2,3, each 4 cycles apart; busy high throughout.
REQ-035 Core 3 requests continuously with core 0 -> grants alternate 0,3,0,3; ptr wraps 3 -> 0.
REQ-036 Reset asserted in CAPTURE of a load to 0x0005 -> no ack, rdata=0, state IDLE; a request pending after reset is then served from core 0 first.
REQ-037 N_CORES=1 instance: repeated loads from core 0 complete every 4 cycles with correct rdata.
